// File: rtl/bank_scheduler.sv
// Bank scheduler for a double-buffered cellular-automaton engine.
// Arbitrates clear, preset-load, manual edit and evolve phases over two
// memory banks, owns the display/source bank select and the generation
// counter, and aborts any granted phase that overruns its cycle budget.
module bank_scheduler #(
   parameter int ADDR_W  = 24,
   parameter int TIMEOUT = 2000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              clear_req,
   input  logic              load_req,
   input  logic              edit_req,
   input  logic [ADDR_W-1:0] edit_addr,
   input  logic              edit_val,
   input  logic              evo_tick,
   input  logic              clear_done,
   input  logic              load_done,
   input  logic              evo_done,
   output logic              clear_gnt,
   output logic              load_gnt,
   output logic              evo_gnt,
   output logic              edit_wr,
   output logic [ADDR_W-1:0] edit_wr_addr,
   output logic              edit_wr_val,
   output logic              bank_sel,
   output logic [15:0]       gen_count,
   output logic              busy,
   output logic              edit_drop,
   output logic              evo_miss,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      EDIT,
      EVOLVE,
      SWAP_WAIT
   } state_t;

   state_t              state;
   state_t              state_n;
   logic [CNT_W-1:0]    phase_cnt;
   logic                edit_full;
   logic [ADDR_W-1:0]   buf_addr;
   logic                buf_val;
   logic                evo_pend;

   logic                in_phase;
   logic                timeout_hit;
   logic                enter_phase;
   logic                enter_evolve;
   logic                clear_ok;
   logic                aborted;
   logic                swap;
   logic                drain;
   logic                evo_keep;

   // Next-state decision and the one-cycle events that go with each transition.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_n      = state;
      enter_phase  = 1'b0;
      enter_evolve = 1'b0;
      clear_ok     = 1'b0;
      aborted      = 1'b0;
      swap         = 1'b0;
      drain        = 1'b0;
      in_phase     = (state inside {CLEAR, LOAD, EVOLVE});
      timeout_hit  = (phase_cnt == CNT_W'(TIMEOUT - 1));

      unique case (state)
         IDLE: begin
            if (clear_req) begin
               state_n     = CLEAR;
               enter_phase = 1'b1;
            end else if (load_req) begin
               state_n     = LOAD;
               enter_phase = 1'b1;
            end else if (edit_full) begin
               state_n = EDIT;
               drain   = 1'b1;
            end else if (evo_pend) begin
               state_n      = EVOLVE;
               enter_phase  = 1'b1;
               enter_evolve = 1'b1;
            end
         end
         CLEAR: begin
            if (clear_done) begin
               state_n  = IDLE;
               clear_ok = 1'b1;
            end else if (timeout_hit) begin
               state_n = IDLE;
               aborted = 1'b1;
            end
         end
         LOAD: begin
            if (load_done) begin
               state_n = IDLE;
            end else if (timeout_hit) begin
               state_n = IDLE;
               aborted = 1'b1;
            end
         end
         EDIT: begin
            state_n = IDLE;
         end
         EVOLVE: begin
            // frame_start on the same edge as evo_done is deliberately not a swap.
            if (evo_done) begin
               state_n = SWAP_WAIT;
            end else if (timeout_hit) begin
               state_n = IDLE;
               aborted = 1'b1;
            end
         end
         SWAP_WAIT: begin
            if (frame_start) begin
               state_n = IDLE;
               swap    = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // A successful clear discards any queued generation; a tick on that same
      // edge is a fresh request and survives.
      evo_keep = evo_pend & ~enter_evolve & ~clear_ok;
   end

   // State register with all outputs registered from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         phase_cnt    <= '0;
         clear_gnt    <= 1'b0;
         load_gnt     <= 1'b0;
         evo_gnt      <= 1'b0;
         busy         <= 1'b0;
         edit_wr      <= 1'b0;
         edit_wr_addr <= '0;
         edit_wr_val  <= 1'b0;
         edit_drop    <= 1'b0;
         evo_miss     <= 1'b0;
         bank_sel     <= 1'b0;
         gen_count    <= '0;
         timeout_err  <= 1'b0;
         edit_full    <= 1'b0;
         evo_pend     <= 1'b0;
         // NOTE: the buffer payload is reset too, so a drained-but-never-filled
         // entry can never put X on the write bus.
         buf_addr     <= '0;
         buf_val      <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every right-hand side sees the
         // pre-edge value regardless of statement order.
         state     <= state_n;
         clear_gnt <= (state_n == CLEAR);
         load_gnt  <= (state_n == LOAD);
         evo_gnt   <= (state_n == EVOLVE);
         busy      <= (state_n != IDLE);

         if (enter_phase) begin
            phase_cnt <= '0;
         end else if (in_phase) begin
            phase_cnt <= phase_cnt + CNT_W'(1);
         end

         if (aborted) begin
            timeout_err <= 1'b1;
         end else if (clear_ok) begin
            timeout_err <= 1'b0;
         end

         if (clear_ok) begin
            bank_sel  <= 1'b0;
            gen_count <= '0;
         end else if (swap) begin
            bank_sel  <= ~bank_sel;
            gen_count <= gen_count + 16'd1;
         end

         // Single-entry edit buffer: a request while occupied is lost, even
         // on the edge that drains it.
         edit_wr   <= drain;
         edit_drop <= edit_req & edit_full;
         if (drain) begin
            edit_wr_addr <= buf_addr;
            edit_wr_val  <= buf_val;
         end
         if (edit_req && !edit_full) begin
            edit_full <= 1'b1;
            buf_addr  <= edit_addr;
            buf_val   <= edit_val;
         end else if (drain) begin
            edit_full <= 1'b0;
         end

         evo_miss <= evo_tick & evo_keep;
         evo_pend <= evo_keep | evo_tick;
      end
   end

endmodule

// File: tb/tb_bank_scheduler.sv
// Testbench for bank_scheduler: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model of the scheduler.
module tb_bank_scheduler;

   localparam int AW = 24;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          frame_start, clear_req, load_req, edit_req, edit_val, evo_tick;
   logic [AW-1:0] edit_addr;
   logic          clear_done, load_done, evo_done;
   logic          clear_gnt, load_gnt, evo_gnt, edit_wr, edit_wr_val;
   logic [AW-1:0] edit_wr_addr;
   logic          bank_sel, busy, edit_drop, evo_miss, timeout_err;
   logic [15:0]   gen_count;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   bank_scheduler #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
      .clear_req(clear_req), .load_req(load_req), .edit_req(edit_req),
      .edit_addr(edit_addr), .edit_val(edit_val), .evo_tick(evo_tick),
      .clear_done(clear_done), .load_done(load_done), .evo_done(evo_done),
      .clear_gnt(clear_gnt), .load_gnt(load_gnt), .evo_gnt(evo_gnt),
      .edit_wr(edit_wr), .edit_wr_addr(edit_wr_addr), .edit_wr_val(edit_wr_val),
      .bank_sel(bank_sel), .gen_count(gen_count), .busy(busy),
      .edit_drop(edit_drop), .evo_miss(evo_miss), .timeout_err(timeout_err)
   );

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_CLEAR, M_LOAD, M_EDIT, M_EVOLVE, M_SWAP} mphase_t;
   mphase_t        m_phase;
   int             m_elapsed;
   bit             m_bank, m_terr, m_pend;
   int             m_gen;
   logic [AW:0]    edit_q[$];
   bit             m_wr, m_wr_val, m_drop, m_miss;
   logic [AW-1:0]  m_wr_addr;

   task automatic model_reset();
      m_phase = M_IDLE; m_elapsed = 0; m_bank = 0; m_gen = 0; m_terr = 0;
      m_pend = 0; edit_q.delete(); m_wr = 0; m_wr_addr = '0; m_wr_val = 0;
      m_drop = 0; m_miss = 0;
   endtask

   task automatic model_edge();
      mphase_t     nxt;
      bit          had_edit, drain, evo_enter, clear_ok, done, keep;
      logic [AW:0] e;
      nxt = m_phase; drain = 0; evo_enter = 0; clear_ok = 0;
      had_edit = (edit_q.size() != 0);
      m_wr = 0; m_drop = 0; m_miss = 0;
      case (m_phase)
         M_IDLE: begin
            if (clear_req)     begin nxt = M_CLEAR; m_elapsed = 0; end
            else if (load_req) begin nxt = M_LOAD; m_elapsed = 0; end
            else if (had_edit) begin nxt = M_EDIT; drain = 1; end
            else if (m_pend)   begin nxt = M_EVOLVE; m_elapsed = 0; evo_enter = 1; end
         end
         M_CLEAR, M_LOAD, M_EVOLVE: begin
            done = (m_phase == M_CLEAR) ? clear_done :
                   (m_phase == M_LOAD)  ? load_done  : evo_done;
            if (done) begin
               if (m_phase == M_CLEAR) begin
                  clear_ok = 1; m_bank = 0; m_gen = 0; m_terr = 0;
               end
               nxt = (m_phase == M_EVOLVE) ? M_SWAP : M_IDLE;
            end else begin
               m_elapsed++;
               if (m_elapsed == TO) begin nxt = M_IDLE; m_terr = 1; end
            end
         end
         M_EDIT: nxt = M_IDLE;
         M_SWAP: if (frame_start) begin
            m_bank = !m_bank; m_gen = (m_gen + 1) % 65536; nxt = M_IDLE;
         end
         default: nxt = M_IDLE;
      endcase
      if (drain) begin
         e = edit_q.pop_front();
         m_wr = 1; m_wr_addr = e[AW:1]; m_wr_val = e[0];
      end
      if (edit_req) begin
         if (had_edit) m_drop = 1;
         else edit_q.push_back({edit_addr, edit_val});
      end
      keep   = m_pend && !evo_enter && !clear_ok;
      m_miss = evo_tick && keep;
      m_pend = keep || evo_tick;
      m_phase = nxt;
   endtask

   // One clock: edge, model update, then settle before sampling.
   task automatic cycle();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      frame_start = 0; clear_req = 0; load_req = 0; edit_req = 0; edit_addr = '0;
      edit_val = 0; evo_tick = 0; clear_done = 0; load_done = 0; evo_done = 0;
   endtask

   // Stimulus only: one full evolve + swap from IDLE.
   task automatic run_generation();
      evo_tick = 1; cycle(); evo_tick = 0; cycle();
      repeat (3) cycle();
      evo_done = 1; cycle(); evo_done = 0;
      frame_start = 1; cycle(); frame_start = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 0; model_reset();
      idle_inputs(); evo_tick = 1; edit_req = 1; frame_start = 1; clear_req = 1;
      repeat (3) cycle();
      checks++; if (clear_gnt !== 1'b0)    $display("FAIL rst_clear_gnt: got %b want 0", clear_gnt); else passed++;
      checks++; if (load_gnt !== 1'b0)     $display("FAIL rst_load_gnt: got %b want 0", load_gnt); else passed++;
      checks++; if (evo_gnt !== 1'b0)      $display("FAIL rst_evo_gnt: got %b want 0", evo_gnt); else passed++;
      checks++; if (edit_wr !== 1'b0)      $display("FAIL rst_edit_wr: got %b want 0", edit_wr); else passed++;
      checks++; if (edit_wr_addr !== '0)   $display("FAIL rst_edit_wr_addr: got %h want 0", edit_wr_addr); else passed++;
      checks++; if (edit_wr_val !== 1'b0)  $display("FAIL rst_edit_wr_val: got %b want 0", edit_wr_val); else passed++;
      checks++; if (bank_sel !== 1'b0)     $display("FAIL rst_bank_sel: got %b want 0", bank_sel); else passed++;
      checks++; if (gen_count !== 16'd0)   $display("FAIL rst_gen_count: got %0d want 0", gen_count); else passed++;
      checks++; if (busy !== 1'b0)         $display("FAIL rst_busy: got %b want 0", busy); else passed++;
      checks++; if (edit_drop !== 1'b0)    $display("FAIL rst_edit_drop: got %b want 0", edit_drop); else passed++;
      checks++; if (evo_miss !== 1'b0)     $display("FAIL rst_evo_miss: got %b want 0", evo_miss); else passed++;
      checks++; if (timeout_err !== 1'b0)  $display("FAIL rst_timeout_err: got %b want 0", timeout_err); else passed++;
      idle_inputs(); reset_n = 1;
      repeat (3) cycle();
      checks++; if (busy !== 1'b0 || edit_wr !== 1'b0) $display("FAIL rst_buffers_empty: busy %b edit_wr %b want 0 0", busy, edit_wr); else passed++;
   endtask

   task automatic test_edit_latency();
      edit_req = 1; edit_addr = 24'h00ABCD; edit_val = 1; cycle(); edit_req = 0;
      checks++; if (edit_wr !== 1'b0) $display("FAIL edit_lat_early: got %b want 0", edit_wr); else passed++;
      cycle();
      checks++; if (edit_wr !== 1'b1 || edit_wr_addr !== 24'h00ABCD || edit_wr_val !== 1'b1)
         $display("FAIL edit_lat_write: got wr %b addr %h val %b want 1 00abcd 1", edit_wr, edit_wr_addr, edit_wr_val); else passed++;
      cycle();
      checks++; if (edit_wr !== 1'b0 || busy !== 1'b0) $display("FAIL edit_lat_one_cycle: wr %b busy %b want 0 0", edit_wr, busy); else passed++;
   endtask

   task automatic test_evolve_swap();
      int n = 0;
      evo_tick = 1; cycle(); evo_tick = 0; cycle();
      for (int i = 0; i < 10; i++) begin
         if (evo_gnt === 1'b1) n++;
         if (i == 9) evo_done = 1;
         cycle();
      end
      evo_done = 0;
      checks++; if (n != 10) $display("FAIL evo_gnt_len: got %0d want 10", n); else passed++;
      checks++; if (evo_gnt !== 1'b0 || busy !== 1'b1) $display("FAIL swap_wait: gnt %b busy %b want 0 1", evo_gnt, busy); else passed++;
      repeat (4) cycle();
      checks++; if (bank_sel !== 1'b0) $display("FAIL pre_swap_bank: got %b want 0", bank_sel); else passed++;
      frame_start = 1; cycle(); frame_start = 0;
      checks++; if (bank_sel !== 1'b1) $display("FAIL swap_bank: got %b want 1", bank_sel); else passed++;
      checks++; if (gen_count !== 16'd1) $display("FAIL swap_gen: got %0d want 1", gen_count); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL swap_idle: got %b want 0", busy); else passed++;
   endtask

   task automatic test_edit_drop();
      int wr_n = 0;
      evo_tick = 1; cycle(); evo_tick = 0; cycle();
      edit_req = 1; edit_addr = 24'h0003E8; edit_val = 1; cycle(); edit_req = 0;
      cycle(); cycle();
      edit_req = 1; edit_addr = 24'h000123; edit_val = 0; cycle(); edit_req = 0;
      checks++; if (edit_drop !== 1'b1) $display("FAIL edit_drop_pulse: got %b want 1", edit_drop); else passed++;
      cycle();
      checks++; if (edit_drop !== 1'b0) $display("FAIL edit_drop_single: got %b want 0", edit_drop); else passed++;
      evo_done = 1; cycle(); evo_done = 0;
      frame_start = 1; cycle(); frame_start = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (edit_wr === 1'b1) begin
            wr_n++;
            checks++; if (edit_wr_addr !== 24'h0003E8 || edit_wr_val !== 1'b1)
               $display("FAIL edit_kept_data: got %h/%b want 0003e8/1", edit_wr_addr, edit_wr_val); else passed++;
         end
      end
      checks++; if (wr_n != 1) $display("FAIL edit_kept_count: got %0d want 1", wr_n); else passed++;
   endtask

   task automatic test_clear_priority();
      int n = 0;
      while (m_gen < 5) run_generation();
      checks++; if (gen_count !== 16'd5 || bank_sel !== 1'b1) $display("FAIL clr_pre: gen %0d bank %b want 5 1", gen_count, bank_sel); else passed++;
      clear_req = 1; evo_tick = 1; cycle(); clear_req = 0; evo_tick = 0;
      checks++; if (clear_gnt !== 1'b1 || evo_gnt !== 1'b0) $display("FAIL clr_first: clear %b evo %b want 1 0", clear_gnt, evo_gnt); else passed++;
      repeat (4) cycle();
      clear_done = 1; cycle(); clear_done = 0;
      checks++; if (clear_gnt !== 1'b0) $display("FAIL clr_gnt_drop: got %b want 0", clear_gnt); else passed++;
      checks++; if (bank_sel !== 1'b0 || gen_count !== 16'd0) $display("FAIL clr_state: bank %b gen %0d want 0 0", bank_sel, gen_count); else passed++;
      repeat (10) begin cycle(); if (evo_gnt === 1'b1) n++; end
      checks++; if (n != 0) $display("FAIL clr_discards_evolve: got %0d evolve cycles want 0", n); else passed++;
   endtask

   task automatic test_timeout();
      int n = 0;
      run_generation();
      evo_tick = 1; cycle(); evo_tick = 0; cycle();
      for (int i = 0; i < 3 * TO && evo_gnt === 1'b1; i++) begin n++; cycle(); end
      checks++; if (n != TO) $display("FAIL to_len: got %0d want %0d", n, TO); else passed++;
      checks++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout_err); else passed++;
      checks++; if (bank_sel !== 1'b1 || gen_count !== 16'd1) $display("FAIL to_bank: bank %b gen %0d want 1 1", bank_sel, gen_count); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else passed++;
      load_req = 1; cycle(); load_req = 0; cycle();
      load_done = 1; cycle(); load_done = 0;
      checks++; if (timeout_err !== 1'b1 || load_gnt !== 1'b0) $display("FAIL to_sticky: err %b gnt %b want 1 0", timeout_err, load_gnt); else passed++;
      clear_req = 1; cycle(); clear_req = 0; cycle();
      clear_done = 1; cycle(); clear_done = 0;
      checks++; if (timeout_err !== 1'b0) $display("FAIL to_cleared: got %b want 0", timeout_err); else passed++;
   endtask

   task automatic test_load_miss();
      int misses = 0, entries = 0;
      logic prev = 1'b0;
      load_req = 1; cycle(); load_req = 0;
      for (int k = 0; k < 3; k++) begin
         evo_tick = 1; cycle(); evo_tick = 0;
         if (evo_miss === 1'b1) misses++;
         cycle();
         if (evo_miss === 1'b1) misses++;
      end
      checks++; if (misses != 2) $display("FAIL load_misses: got %0d want 2", misses); else passed++;
      load_done = 1; cycle(); load_done = 0;
      for (int i = 0; i < 60; i++) begin
         evo_done = (m_phase == M_EVOLVE) && (i % 4 == 3);
         frame_start = (i % 10 == 9);
         cycle();
         if (evo_gnt === 1'b1 && prev !== 1'b1) entries++;
         prev = evo_gnt;
      end
      idle_inputs();
      checks++; if (entries != 1) $display("FAIL load_one_evolve: got %0d want 1", entries); else passed++;
      checks++; if (gen_count !== 16'd1 || bank_sel !== 1'b1) $display("FAIL load_gen: gen %0d bank %b want 1 1", gen_count, bank_sel); else passed++;
   endtask

   task automatic test_reset_midphase();
      evo_tick = 1; cycle(); evo_tick = 0; cycle(); cycle();
      checks++; if (evo_gnt !== 1'b1) $display("FAIL mid_gnt_on: got %b want 1", evo_gnt); else passed++;
      #2 reset_n = 0; model_reset();
      #1;
      checks++; if (evo_gnt !== 1'b0 || busy !== 1'b0) $display("FAIL mid_async_drop: gnt %b busy %b want 0 0", evo_gnt, busy); else passed++;
      cycle(); reset_n = 1; cycle();
      evo_tick = 1; cycle(); evo_tick = 0; cycle(); cycle();
      evo_done = 1; cycle(); evo_done = 0;
      checks++; if (busy !== 1'b1 || evo_gnt !== 1'b0) $display("FAIL sw_wait_entry: busy %b gnt %b want 1 0", busy, evo_gnt); else passed++;
      reset_n = 0; model_reset();
      frame_start = 1; cycle(); frame_start = 0;
      reset_n = 1; cycle(); cycle();
      checks++; if (bank_sel !== 1'b0 || gen_count !== 16'd0 || busy !== 1'b0)
         $display("FAIL sw_reset: bank %b gen %0d busy %b want 0 0 0", bank_sel, gen_count, busy); else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         clear_req   = ($urandom_range(0, 59) == 0);
         load_req    = ($urandom_range(0, 39) == 0);
         edit_req    = ($urandom_range(0, 4) == 0);
         edit_addr   = AW'($urandom);
         edit_val    = 1'($urandom_range(0, 1));
         evo_tick    = ($urandom_range(0, 6) == 0);
         frame_start = ($urandom_range(0, 11) == 0);
         clear_done  = (m_phase == M_CLEAR  && $urandom_range(0, 7) == 0)  || $urandom_range(0, 49) == 0;
         load_done   = (m_phase == M_LOAD   && $urandom_range(0, 7) == 0)  || $urandom_range(0, 49) == 0;
         evo_done    = (m_phase == M_EVOLVE && $urandom_range(0, 29) == 0) || $urandom_range(0, 49) == 0;
         cycle();
         checks++; if (clear_gnt !== (m_phase == M_CLEAR))  $display("FAIL rnd_clear_gnt @%0d: got %b want %b", i, clear_gnt, m_phase == M_CLEAR); else passed++;
         checks++; if (load_gnt !== (m_phase == M_LOAD))    $display("FAIL rnd_load_gnt @%0d: got %b want %b", i, load_gnt, m_phase == M_LOAD); else passed++;
         checks++; if (evo_gnt !== (m_phase == M_EVOLVE))   $display("FAIL rnd_evo_gnt @%0d: got %b want %b", i, evo_gnt, m_phase == M_EVOLVE); else passed++;
         checks++; if (busy !== (m_phase != M_IDLE))        $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, m_phase != M_IDLE); else passed++;
         checks++; if (edit_wr !== m_wr)                    $display("FAIL rnd_edit_wr @%0d: got %b want %b", i, edit_wr, m_wr); else passed++;
         checks++; if (edit_wr_addr !== m_wr_addr || edit_wr_val !== m_wr_val)
            $display("FAIL rnd_edit_data @%0d: got %h/%b want %h/%b", i, edit_wr_addr, edit_wr_val, m_wr_addr, m_wr_val); else passed++;
         checks++; if (edit_drop !== m_drop)                $display("FAIL rnd_edit_drop @%0d: got %b want %b", i, edit_drop, m_drop); else passed++;
         checks++; if (evo_miss !== m_miss)                 $display("FAIL rnd_evo_miss @%0d: got %b want %b", i, evo_miss, m_miss); else passed++;
         checks++; if (bank_sel !== m_bank)                 $display("FAIL rnd_bank_sel @%0d: got %b want %b", i, bank_sel, m_bank); else passed++;
         checks++; if (gen_count !== 16'(m_gen))            $display("FAIL rnd_gen_count @%0d: got %0d want %0d", i, gen_count, m_gen); else passed++;
         checks++; if (timeout_err !== m_terr)              $display("FAIL rnd_timeout_err @%0d: got %b want %b", i, timeout_err, m_terr); else passed++;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset_n = 0;
      model_reset();
      test_reset();
      test_edit_latency();
      test_evolve_swap();
      test_edit_drop();
      test_clear_priority();
      test_timeout();
      test_load_miss();
      test_reset_midphase();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
